cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
// Shares the single line-wide memory port between I$ line refills and D$ line refills/write-backs.
// Sits between the I$/D$ replace logic and the bus/memory controller.
// Grants one requester at a time, round-robin on contention, one outstanding transaction.
// Registers address and data at grant, holds them stable until memory signals completion.
// PARAMETERS
// MEM_ADDR_WIDTH   30    line address width (PADDR_WIDTH - log2(line size)); equals DCACHE/ICACHE_MEM_ADDR_WIDTH
// LINE_WIDTH       128   line width in bits; equals DCACHE_LINE_WIDTH
// PORTS
// clk               in   1               clock
// rst               in   1               synchronous reset, active-high
// icacheReadReq     in   1               I$ refill request, level, held until icacheReadGrant
// icacheAddr        in   MEM_ADDR_WIDTH  I$ line address
// icacheReadGrant   out  1               one-cycle pulse: I$ read complete, icacheReadValue valid
// icacheReadValue   out  LINE_WIDTH      refill data
// dcacheReadReq     in   1               D$ refill request, level
// dcacheWriteReq    in   1               D$ write-back/write-through request, level
// dcacheAddr        in   MEM_ADDR_WIDTH  D$ line address
// dcacheWriteValue  in   LINE_WIDTH      D$ write data
// dcacheReadGrant   out  1               one-cycle pulse: D$ read complete, dcacheReadValue valid
// dcacheWriteGrant  out  1               one-cycle pulse: D$ write accepted by memory
// dcacheReadValue   out  LINE_WIDTH      refill data
// memAddr           out  MEM_ADDR_WIDTH  memory line address
// memReadEnable     out  1               memory read in progress
// memWriteEnable    out  1               memory write in progress
// memWriteValue     out  LINE_WIDTH      memory write data
// memReadDone       in   1               read data valid on memReadValue this cycle
// memWriteDone      in   1               write accepted this cycle
// memReadValue      in   LINE_WIDTH      memory read data
// BEHAVIOUR
// - States: IDLE, IC_READ, DC_READ, DC_WRITE. Reset: state=IDLE, preferDCache=1, memAddr/memWriteValue=0,
//   memReadEnable=memWriteEnable=0, all grants 0; read value outputs pass memReadValue (don't-care while grant=0).
// - memReadEnable = (state==IC_READ||state==DC_READ); memWriteEnable = (state==DC_WRITE); both registered-state decoded.
// - IDLE selection (evaluated every IDLE cycle): I$ req only -> IC_READ; D$ req only -> DC_WRITE if dcacheWriteReq
//   else DC_READ; both I$ and D$ -> D$ if preferDCache else I$. On the transition edge memAddr (and memWriteValue
//   for DC_WRITE) latch the winner's inputs; preferDCache <= (winner is I$).
// - dcacheReadReq and dcacheWriteReq both high: write wins (dirty line written back before refill).
// - Busy state held until the matching done: IC_READ/DC_READ exit on memReadDone, DC_WRITE on memWriteDone -> IDLE.
// - Grant = matching done AND owner state, combinational, same cycle; read value = memReadValue, combinational.
// - Latency: req high in IDLE at cycle 0 -> enable high cycle 1; done at cycle k -> grant cycle k, IDLE cycle k+1,
//   next transaction enable at k+2 at the earliest (one bubble, intentional).
// - memAddr/memWriteValue stable for the whole busy period regardless of requester input changes.
// - Requester dropping req mid-transaction: transaction still completes, grant still pulses.
// - memReadDone/memWriteDone in IDLE or non-matching state: ignored, no grant, no state change.
// - Requester must deassert req in the cycle after its grant; still-high req is treated as a new request.
// - rst mid-transaction: next cycle state=IDLE, enables 0, no grant pulse; memory side shares rst and aborts.
// TESTING
// - I$ alone: icacheReadReq=1, icacheAddr=0x1234 -> memReadEnable=1,memAddr=0x1234 next cycle; memReadDone with
//   0xDEAD..BEEF -> icacheReadGrant=1 same cycle, icacheReadValue=0xDEAD..BEEF, then IDLE.
// - Contention after reset: I$ and D$ read both high -> D$ served first, then I$; repeat -> alternates D$,I$,D$,I$.
// - D$ read+write both high, addr 0x40, data 0xA5.. -> DC_WRITE with memWriteValue=0xA5..; memWriteDone ->
//   dcacheWriteGrant=1 only; no dcacheReadGrant.
// - Stability: change dcacheAddr/WriteValue during DC_WRITE, delay memWriteDone 5 cycles -> memAddr/memWriteValue unchanged.
// - Spurious done: memReadDone pulse in IDLE and memWriteDone during IC_READ -> no grants, state unchanged.
// - Reset mid-read: rst during IC_READ -> enables 0 next cycle, no grant, preferDCache=1, next contention picks D$.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-wide memory port between I$ refills
// and D$ refills/write-backs, round-robin, one transaction in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   icacheReadReq/Addr            I$ refill request (level) and line address
//   icacheReadGrant/ReadValue     I$ completion pulse and refill data
//   dcacheReadReq/WriteReq        D$ refill / write-back requests (level)
//   dcacheAddr/WriteValue         D$ line address and write data
//   dcacheReadGrant/WriteGrant    D$ completion pulses
//   dcacheReadValue               D$ refill data
//   memAddr/ReadEnable/WriteEnable/WriteValue   memory request side
//   memReadDone/WriteDone/ReadValue             memory completion side
module cache_mem_arbiter #(
    parameter int MEM_ADDR_WIDTH = 30,
    parameter int LINE_WIDTH     = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      icacheReadReq,
    input  logic [MEM_ADDR_WIDTH-1:0] icacheAddr,
    output logic                      icacheReadGrant,
    output logic [LINE_WIDTH-1:0]     icacheReadValue,
    input  logic                      dcacheReadReq,
    input  logic                      dcacheWriteReq,
    input  logic [MEM_ADDR_WIDTH-1:0] dcacheAddr,
    input  logic [LINE_WIDTH-1:0]     dcacheWriteValue,
    output logic                      dcacheReadGrant,
    output logic                      dcacheWriteGrant,
    output logic [LINE_WIDTH-1:0]     dcacheReadValue,
    output logic [MEM_ADDR_WIDTH-1:0] memAddr,
    output logic                      memReadEnable,
    output logic                      memWriteEnable,
    output logic [LINE_WIDTH-1:0]     memWriteValue,
    input  logic                      memReadDone,
    input  logic                      memWriteDone,
    input  logic [LINE_WIDTH-1:0]     memReadValue
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IC_READ  = 2'd1;
    localparam logic [1:0] DC_READ  = 2'd2;
    localparam logic [1:0] DC_WRITE = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       prefer_dcache;
    logic       dc_req;
    logic       pick_ic;
    logic       pick_dc;

    assign dc_req  = dcacheReadReq | dcacheWriteReq;
    // I$ wins when alone, or on contention when it is its turn.
    assign pick_ic = icacheReadReq & (~dc_req | ~prefer_dcache);
    assign pick_dc = dc_req & ~pick_ic;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                // A pending write-back goes before the refill of the same line.
                unique case (1'b1)
                    pick_ic:                    state_nxt = IC_READ;
                    pick_dc & dcacheWriteReq:   state_nxt = DC_WRITE;
                    pick_dc & ~dcacheWriteReq:  state_nxt = DC_READ;
                    default:                    state_nxt = IDLE;
                endcase
            end
            IC_READ,
            DC_READ: begin
                if (memReadDone) state_nxt = IDLE;
            end
            DC_WRITE: begin
                if (memWriteDone) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data are captured only when leaving IDLE, so they stay
    // stable for the whole busy period whatever the requesters do.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            prefer_dcache <= 1'b1;
            memAddr       <= '0;
            memWriteValue <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (pick_ic) begin
                    memAddr       <= icacheAddr;
                    prefer_dcache <= 1'b1;
                end else if (pick_dc) begin
                    memAddr       <= dcacheAddr;
                    prefer_dcache <= 1'b0;
                    if (dcacheWriteReq) memWriteValue <= dcacheWriteValue;
                end
            end
        end
    end

    assign memReadEnable  = (state == IC_READ) || (state == DC_READ);
    assign memWriteEnable = (state == DC_WRITE);

    assign icacheReadGrant  = (state == IC_READ)  & memReadDone;
    assign dcacheReadGrant  = (state == DC_READ)  & memReadDone;
    assign dcacheWriteGrant = (state == DC_WRITE) & memWriteDone;

    assign icacheReadValue = memReadValue;
    assign dcacheReadValue = memReadValue;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed tests for cache_mem_arbiter.
// Inputs change on negedge; outputs checked 1 time unit later.
module tb_cache_mem_arbiter;

    localparam int AW = 30;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          icacheReadReq;
    logic [AW-1:0] icacheAddr;
    logic          icacheReadGrant;
    logic [LW-1:0] icacheReadValue;
    logic          dcacheReadReq;
    logic          dcacheWriteReq;
    logic [AW-1:0] dcacheAddr;
    logic [LW-1:0] dcacheWriteValue;
    logic          dcacheReadGrant;
    logic          dcacheWriteGrant;
    logic [LW-1:0] dcacheReadValue;
    logic [AW-1:0] memAddr;
    logic          memReadEnable;
    logic          memWriteEnable;
    logic [LW-1:0] memWriteValue;
    logic          memReadDone;
    logic          memWriteDone;
    logic [LW-1:0] memReadValue;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .MEM_ADDR_WIDTH(AW),
        .LINE_WIDTH    (LW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .icacheReadReq   (icacheReadReq),
        .icacheAddr      (icacheAddr),
        .icacheReadGrant (icacheReadGrant),
        .icacheReadValue (icacheReadValue),
        .dcacheReadReq   (dcacheReadReq),
        .dcacheWriteReq  (dcacheWriteReq),
        .dcacheAddr      (dcacheAddr),
        .dcacheWriteValue(dcacheWriteValue),
        .dcacheReadGrant (dcacheReadGrant),
        .dcacheWriteGrant(dcacheWriteGrant),
        .dcacheReadValue (dcacheReadValue),
        .memAddr         (memAddr),
        .memReadEnable   (memReadEnable),
        .memWriteEnable  (memWriteEnable),
        .memWriteValue   (memWriteValue),
        .memReadDone     (memReadDone),
        .memWriteDone    (memWriteDone),
        .memReadValue    (memReadValue)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        memReadValue = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({memReadEnable, memWriteEnable} !== 2'b00) begin
            fails++;
            $display("FAIL reset_en got=%b exp=00",
                     {memReadEnable, memWriteEnable});
        end
        tests++;
        if (memAddr !== '0 || memWriteValue !== '0) begin
            fails++;
            $display("FAIL reset_regs addr=%h wdata=%h exp=0",
                     memAddr, memWriteValue);
        end
        tests++;
        if ({icacheReadGrant, dcacheReadGrant, dcacheWriteGrant} !== 3'b000) begin
            fails++;
            $display("FAIL reset_grants got=%b exp=000",
                     {icacheReadGrant, dcacheReadGrant, dcacheWriteGrant});
        end
        tests++;
        if (icacheReadValue !== memReadValue || dcacheReadValue !== memReadValue) begin
            fails++;
            $display("FAIL reset_passthru i=%h d=%h exp=%h",
                     icacheReadValue, dcacheReadValue, memReadValue);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_icache_alone();
        logic [LW-1:0] line;
        line = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        @(negedge clk);
        icacheReadReq = 1'b1;
        icacheAddr    = 30'h1234;
        @(negedge clk);
        #1;
        tests++;
        if (memReadEnable !== 1'b1 || memWriteEnable !== 1'b0 ||
            memAddr !== 30'h1234) begin
            fails++;
            $display("FAIL ic_issue re=%b we=%b addr=%h exp re=1 we=0 addr=1234",
                     memReadEnable, memWriteEnable, memAddr);
        end
        memReadDone   = 1'b1;
        memReadValue  = line;
        icacheReadReq = 1'b0;
        #1;
        tests++;
        if (icacheReadGrant !== 1'b1 || icacheReadValue !== line ||
            dcacheReadGrant !== 1'b0) begin
            fails++;
            $display("FAIL ic_grant g=%b dg=%b val=%h exp g=1 dg=0 val=%h",
                     icacheReadGrant, dcacheReadGrant, icacheReadValue, line);
        end
        @(negedge clk);
        memReadDone = 1'b0;
        #1;
        tests++;
        if (memReadEnable !== 1'b0 || icacheReadGrant !== 1'b0) begin
            fails++;
            $display("FAIL ic_idle re=%b g=%b exp 0 0",
                     memReadEnable, icacheReadGrant);
        end
    endtask

    // Both sides hold read requests; winner drops its request on grant
    // and re-raises it in the bubble cycle.
    task automatic test_contention();
        logic exp_dc;
        exp_dc = 1'b1;
        icacheAddr = 30'h111;
        dcacheAddr = 30'h222;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            icacheReadReq = 1'b1;
            dcacheReadReq = 1'b1;
            memReadDone   = 1'b0;
            @(negedge clk);
            #1;
            tests++;
            if (memReadEnable !== 1'b1 ||
                memAddr !== (exp_dc ? 30'h222 : 30'h111)) begin
                fails++;
                $display("FAIL cont_addr round=%0d re=%b addr=%h exp_dc=%b",
                         r, memReadEnable, memAddr, exp_dc);
            end
            memReadDone  = 1'b1;
            memReadValue = {4{r[31:0]}};
            if (exp_dc) dcacheReadReq = 1'b0;
            else        icacheReadReq = 1'b0;
            #1;
            tests++;
            if (dcacheReadGrant !== exp_dc || icacheReadGrant !== !exp_dc) begin
                fails++;
                $display("FAIL cont_grant round=%0d ig=%b dg=%b exp_dc=%b",
                         r, icacheReadGrant, dcacheReadGrant, exp_dc);
            end
            exp_dc = !exp_dc;
        end
        @(negedge clk);
        memReadDone   = 1'b0;
        icacheReadReq = 1'b0;
        dcacheReadReq = 1'b0;
    endtask

    task automatic test_write_priority_stable();
        logic [LW-1:0] wd;
        wd = {4{32'hA5A5_A5A5}};
        @(negedge clk);
        dcacheReadReq    = 1'b1;
        dcacheWriteReq   = 1'b1;
        dcacheAddr       = 30'h40;
        dcacheWriteValue = wd;
        @(negedge clk);
        #1;
        tests++;
        if (memWriteEnable !== 1'b1 || memReadEnable !== 1'b0 ||
            memAddr !== 30'h40 || memWriteValue !== wd) begin
            fails++;
            $display("FAIL wr_issue we=%b re=%b addr=%h wd=%h",
                     memWriteEnable, memReadEnable, memAddr, memWriteValue);
        end
        dcacheAddr       = 30'h99;
        dcacheWriteValue = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            tests++;
            if (memWriteEnable !== 1'b1 || memAddr !== 30'h40 ||
                memWriteValue !== wd || dcacheWriteGrant !== 1'b0) begin
                fails++;
                $display("FAIL wr_stable cyc=%0d we=%b addr=%h wd=%h wg=%b",
                         c, memWriteEnable, memAddr, memWriteValue,
                         dcacheWriteGrant);
            end
        end
        memWriteDone   = 1'b1;
        dcacheReadReq  = 1'b0;
        dcacheWriteReq = 1'b0;
        #1;
        tests++;
        if (dcacheWriteGrant !== 1'b1 || dcacheReadGrant !== 1'b0 ||
            icacheReadGrant !== 1'b0) begin
            fails++;
            $display("FAIL wr_grant wg=%b rg=%b ig=%b exp 1 0 0",
                     dcacheWriteGrant, dcacheReadGrant, icacheReadGrant);
        end
        @(negedge clk);
        memWriteDone = 1'b0;
        #1;
        tests++;
        if (memWriteEnable !== 1'b0) begin
            fails++;
            $display("FAIL wr_idle we=%b exp 0", memWriteEnable);
        end
    endtask

    task automatic test_spurious_done();
        @(negedge clk);
        memReadDone  = 1'b1;
        memWriteDone = 1'b1;
        #1;
        tests++;
        if ({icacheReadGrant, dcacheReadGrant, dcacheWriteGrant} !== 3'b000) begin
            fails++;
            $display("FAIL spur_idle_grant got=%b exp=000",
                     {icacheReadGrant, dcacheReadGrant, dcacheWriteGrant});
        end
        @(negedge clk);
        memReadDone  = 1'b0;
        memWriteDone = 1'b0;
        #1;
        tests++;
        if ({memReadEnable, memWriteEnable} !== 2'b00) begin
            fails++;
            $display("FAIL spur_idle_state en=%b exp=00",
                     {memReadEnable, memWriteEnable});
        end
        icacheReadReq = 1'b1;
        icacheAddr    = 30'h3AB;
        @(negedge clk);
        icacheReadReq = 1'b0;
        memWriteDone  = 1'b1;
        #1;
        tests++;
        if (icacheReadGrant !== 1'b0 || dcacheWriteGrant !== 1'b0) begin
            fails++;
            $display("FAIL spur_busy_grant ig=%b wg=%b exp 0 0",
                     icacheReadGrant, dcacheWriteGrant);
        end
        @(negedge clk);
        memWriteDone = 1'b0;
        #1;
        tests++;
        if (memReadEnable !== 1'b1 || memAddr !== 30'h3AB) begin
            fails++;
            $display("FAIL spur_busy_state re=%b addr=%h exp re=1 addr=3ab",
                     memReadEnable, memAddr);
        end
    endtask

    // Entered while still in IC_READ from the previous task.
    task automatic test_reset_mid_read();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        memReadDone = 1'b1;
        #1;
        tests++;
        if ({memReadEnable, memWriteEnable} !== 2'b00 ||
            icacheReadGrant !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid en=%b ig=%b exp en=00 ig=0",
                     {memReadEnable, memWriteEnable}, icacheReadGrant);
        end
        @(negedge clk);
        memReadDone   = 1'b0;
        icacheReadReq = 1'b1;
        dcacheReadReq = 1'b1;
        icacheAddr    = 30'h5;
        dcacheAddr    = 30'h6;
        @(negedge clk);
        #1;
        tests++;
        if (memAddr !== 30'h6 || memReadEnable !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pick addr=%h re=%b exp addr=6 re=1",
                     memAddr, memReadEnable);
        end
        // D$ now won, so preference points at I$; reset must restore D$.
        icacheReadReq = 1'b0;
        dcacheReadReq = 1'b0;
        memReadDone   = 1'b1;
        @(negedge clk);
        memReadDone = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        icacheReadReq = 1'b1;
        dcacheReadReq = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (memAddr !== 30'h6) begin
            fails++;
            $display("FAIL rst_prefer addr=%h exp=6", memAddr);
        end
        memReadDone = 1'b1;
        #1;
        tests++;
        if (dcacheReadGrant !== 1'b1 || icacheReadGrant !== 1'b0) begin
            fails++;
            $display("FAIL rst_prefer_grant dg=%b ig=%b exp 1 0",
                     dcacheReadGrant, icacheReadGrant);
        end
        @(negedge clk);
        memReadDone   = 1'b0;
        icacheReadReq = 1'b0;
        dcacheReadReq = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        icacheReadReq    = 1'b0;
        icacheAddr       = '0;
        dcacheReadReq    = 1'b0;
        dcacheWriteReq   = 1'b0;
        dcacheAddr       = '0;
        dcacheWriteValue = '0;
        memReadDone      = 1'b0;
        memWriteDone     = 1'b0;
        memReadValue     = '0;
        test_reset();
        test_icache_alone();
        test_contention();
        test_write_priority_stable();
        test_spurious_done();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
